// File: rtl/register_pipe_elastic.sv
// rtl/register_pipe_elastic.sv - elastic valid/ready register pipeline; optional occupancy counter via REGISTER_PIPE_ELASTIC_OCCUPANCY_EN
module register_pipe_elastic #(
    parameter int                    WORD_WIDTH  = 8,
    parameter int                    PIPE_DEPTH  = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    COUNT_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   flush,
    input  logic [WORD_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WORD_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] occupancy
);

    // Refuse to build a pipeline with no stages or a counter too narrow for a full pipe.
    generate
        if (PIPE_DEPTH < 1) begin : g_bad_depth
            $error("register_pipe_elastic: PIPE_DEPTH must be at least 1");
        end
        if ((64'd1 << COUNT_WIDTH) <= 64'(PIPE_DEPTH)) begin : g_bad_count
            $error("register_pipe_elastic: COUNT_WIDTH too narrow for PIPE_DEPTH");
        end
    endgenerate

    logic [PIPE_DEPTH-1:0][WORD_WIDTH-1:0] data_q;
    logic [PIPE_DEPTH-1:0][WORD_WIDTH-1:0] data_d;
    logic [PIPE_DEPTH-1:0]                 valid_q;
    logic [PIPE_DEPTH-1:0]                 valid_d;
    logic [PIPE_DEPTH-1:0]                 ready;
    logic                                  ready_acc;
    logic                                  up_valid;
    logic [WORD_WIDTH-1:0]                 up_data;

    // Ready chain: a stage can load if it, or any stage after it, is empty, or the sink takes a word.
    // This is a deliberate combinational path from out_ready through every stage to in_ready.
    always_comb begin
        ready_acc = out_ready;
        ready     = '0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            ready_acc = ~valid_q[k] | ready_acc;
            ready[k]  = ready_acc;
        end
    end

    // Next state: each ready stage takes its upstream neighbour; flush empties everything and wins.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        up_valid = in_valid;
        up_data  = in_data;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (ready[k]) begin
                valid_d[k] = up_valid;
                data_d[k]  = up_data;
            end
            up_valid = valid_q[k];
            up_data  = data_q[k];
        end
        if (flush) begin
            valid_d = '0;
            data_d  = {PIPE_DEPTH{RESET_VALUE}};
        end
    end

    // Stage registers, cleared asynchronously so the output drops without waiting for a clock.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            valid_q <= '0;
            data_q  <= {PIPE_DEPTH{RESET_VALUE}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[PIPE_DEPTH-1];
    assign out_data  = data_q[PIPE_DEPTH-1];

`ifdef REGISTER_PIPE_ELASTIC_OCCUPANCY_EN
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   in_fire;
    logic                   out_fire;

    // Occupancy moves only when exactly one side of the pipe completes a handshake.
    always_comb begin
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
        count_d  = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_fire && !out_fire) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (out_fire && !in_fire) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign occupancy = count_q;
`else
    assign occupancy = '0;
`endif

endmodule

// File: tb/tb_register_pipe_elastic.sv
// tb/tb_register_pipe_elastic.sv - directed self-checking bench for register_pipe_elastic
module tb_register_pipe_elastic;

`ifdef REGISTER_PIPE_ELASTIC_OCCUPANCY_EN
    localparam bit OCC_EN = 1'b1;
`else
    localparam bit OCC_EN = 1'b0;
`endif

    logic       clock;
    logic       clear_n;
    logic       flush;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] occupancy;

    int checks;
    int failures;

    register_pipe_elastic #(
        .WORD_WIDTH (8),
        .PIPE_DEPTH (4),
        .RESET_VALUE(8'h00),
        .COUNT_WIDTH(4)
    ) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .flush    (flush),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] exp_occ(input int n);
        return OCC_EN ? 4'(n) : 4'd0;
    endfunction

    // Move from the sampling point (negedge) through the next active edge to posedge+1.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_n   = 1'b0;
        flush     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        clear_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            in_valid = (c < 16);
            in_data  = 8'(c + 1);
            @(negedge clock);
            if (c < 16) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready); end
            end
            checks++;
            if (out_valid !== (c >= 4 && c < 20)) begin
                failures++; $display("FAIL stream_out_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 4 && c < 20));
            end
            if (c >= 4 && c < 20) begin
                checks++; if (out_data !== 8'(c - 3)) begin failures++; $display("FAIL stream_out_data c=%0d got=%h exp=%h", c, out_data, 8'(c - 3)); end
            end
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall_fill();
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = (c < 4) ? 8'(8'h0A + c) : 8'h0E;
            @(negedge clock);
            checks++; if (in_ready !== (c < 4)) begin failures++; $display("FAIL stall_in_ready c=%0d got=%b exp=%b", c, in_ready, (c < 4)); end
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h0A) begin failures++; $display("FAIL stall_head got=%b/%h exp=1/0a", out_valid, out_data); end
        checks++; if (occupancy !== exp_occ(4)) begin failures++; $display("FAIL stall_occupancy got=%0d exp=%0d", occupancy, exp_occ(4)); end
        next_cycle();
        out_ready = 1'b1;
        for (int d = 0; d < 5; d++) begin
            @(negedge clock);
            checks++; if (out_valid !== (d < 4)) begin failures++; $display("FAIL stall_drain_valid d=%0d got=%b exp=%b", d, out_valid, (d < 4)); end
            if (d < 4) begin
                checks++; if (out_data !== 8'(8'h0A + d)) begin failures++; $display("FAIL stall_drain_data d=%0d got=%h exp=%h", d, out_data, 8'(8'h0A + d)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_bubble_collapse();
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0) || (c == 3);
            in_data  = (c == 3) ? 8'h22 : 8'h11;
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin failures++; $display("FAIL bubble_head got=%b/%h exp=1/11", out_valid, out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready got=%b exp=1", in_ready); end
        checks++; if (occupancy !== exp_occ(2)) begin failures++; $display("FAIL bubble_occupancy got=%0d exp=%0d", occupancy, exp_occ(2)); end
        next_cycle();
        out_ready = 1'b1;
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin failures++; $display("FAIL bubble_first got=%b/%h exp=1/11", out_valid, out_data); end
        next_cycle();
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h22) begin failures++; $display("FAIL bubble_second got=%b/%h exp=1/22", out_valid, out_data); end
        next_cycle();
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_empty got=%b exp=0", out_valid); end
        next_cycle();
    endtask

    task automatic test_full_pass_through();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h31 + c);
            next_cycle();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h31) begin failures++; $display("FAIL full_head got=%b/%h exp=1/31", out_valid, out_data); end
        next_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        checks++; if (out_data !== 8'h32) begin failures++; $display("FAIL full_next got=%h exp=32", out_data); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_still_full got=%b exp=0", in_ready); end
        checks++; if (occupancy !== exp_occ(4)) begin failures++; $display("FAIL full_occupancy got=%0d exp=%0d", occupancy, exp_occ(4)); end
        next_cycle();
        out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_data !== ((d == 3) ? 8'h55 : 8'(8'h32 + d))) begin
                failures++; $display("FAIL full_drain d=%0d got=%b/%h exp=1/%h", d, out_valid, out_data, (d == 3) ? 8'h55 : 8'(8'h32 + d));
            end
            next_cycle();
        end
    endtask

    task automatic test_flush_collision();
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c < 3);
            in_data  = 8'(8'h61 + c);
            next_cycle();
        end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b1;
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin failures++; $display("FAIL flush_pre got=%b/%h exp=1/61", out_valid, out_data); end
        next_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL flush_out_data got=%h exp=00", out_data); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy); end
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            @(negedge clock);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak c=%0d got=%b/%h exp=0", c, out_valid, out_data); end
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h81 + c);
            next_cycle();
        end
        @(negedge clock);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h82) begin failures++; $display("FAIL areset_pre got=%b/%h exp=1/82", out_valid, out_data); end
        #2;
        clear_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL areset_out_data got=%h exp=00", out_data); end
        checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL areset_occupancy got=%0d exp=0", occupancy); end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        clear_n = 1'b1;
        next_cycle();
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_after got=%b exp=0", out_valid); end
        next_cycle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_bubble_collapse();
        test_full_pass_through();
        test_flush_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
